time_keeper_bcd: RTL and testbench

Time-of-day counter for the clock project. It runs a seconds prescaler, keeps hours:minutes:seconds in BCD, and supports manual setting of hours and minutes. It sits directly upstream of the multiplexed 4-digit display driver and feeds that driver its four BCD digit inputs: minute units, minute tens, hour units and hour tens.

---
 rtl/time_keeper_bcd.sv | 143 ++++++++++++++
 tb/tb_time_keeper_bcd.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/time_keeper_bcd.sv
// Time-of-day keeper: seconds prescaler, BCD hours:minutes:seconds, manual set of hours/minutes.
// Optional alarm output is compiled in when TIME_KEEPER_ALARM_EN is defined.
module time_keeper_bcd #(
  parameter int TICKS_PER_SEC = 100
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       set_mode,
  input  logic       inc_min,
  input  logic       inc_h,
`ifdef TIME_KEEPER_ALARM_EN
  input  logic       alarm_en,
  input  logic [7:0] alarm_h_bcd,
  input  logic [7:0] alarm_min_bcd,
  output logic       alarm_out,
`endif
  output logic [3:0] d0_min_out,
  output logic [3:0] d1_min_out,
  output logic [3:0] d0_h_out,
  output logic [3:0] d1_h_out,
  output logic       sec_tick,
  output logic       colon_on
);

  localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [PW-1:0] HALF = PW'(TICKS_PER_SEC / 2);

  logic [PW-1:0] presc_reg, presc_next;
  logic [5:0]    sec_reg, sec_next;
  logic [3:0]    min0_reg, min1_reg, hr0_reg, hr1_reg;
  logic [3:0]    min0_next, min1_next, hr0_next, hr1_next;
  logic [3:0]    min0_inc, min1_inc, hr0_inc, hr1_inc;
  logic          sec_tick_reg, colon_reg;
  logic          inc_min_prev_reg, inc_h_prev_reg;
  logic          tick, sec_wrap, min_wrap, do_min, do_hr;
`ifdef TIME_KEEPER_ALARM_EN
  logic          alarm_reg, alarm_next;
`endif

  always_comb begin
    presc_next = '0;
    sec_next   = sec_reg;
    tick       = sec_tick_reg && !set_mode;
    sec_wrap   = tick && (sec_reg == 6'd59);
    min_wrap   = (min0_reg == 4'd9) && (min1_reg == 4'd5);

    // Prescaler and seconds restart from zero whenever set mode is active.
    if (set_mode) begin
      sec_next = '0;
    end else begin
      presc_next = (presc_reg == LAST) ? '0 : presc_reg + 1'b1;
      if (tick)
        sec_next = sec_wrap ? 6'd0 : sec_reg + 6'd1;
    end

    min0_inc = min0_reg + 4'd1;
    min1_inc = min1_reg;
    if (min0_reg == 4'd9) begin
      min0_inc = 4'd0;
      min1_inc = (min1_reg == 4'd5) ? 4'd0 : min1_reg + 4'd1;
    end

    hr0_inc = hr0_reg + 4'd1;
    hr1_inc = hr1_reg;
    if (hr1_reg == 4'd2 && hr0_reg == 4'd3) begin
      hr0_inc = 4'd0;
      hr1_inc = 4'd0;
    end else if (hr0_reg == 4'd9) begin
      hr0_inc = 4'd0;
      hr1_inc = hr1_reg + 4'd1;
    end

    // In set mode the buttons drive the increments and no carry crosses minutes->hours.
    if (set_mode) begin
      do_min = inc_min && !inc_min_prev_reg;
      do_hr  = inc_h && !inc_h_prev_reg;
    end else begin
      do_min = sec_wrap;
      do_hr  = sec_wrap && min_wrap;
    end

    min0_next = do_min ? min0_inc : min0_reg;
    min1_next = do_min ? min1_inc : min1_reg;
    hr0_next  = do_hr  ? hr0_inc  : hr0_reg;
    hr1_next  = do_hr  ? hr1_inc  : hr1_reg;
  end

`ifdef TIME_KEEPER_ALARM_EN
  always_comb begin
    alarm_next = alarm_reg;
    if (set_mode || !alarm_en)
      alarm_next = 1'b0;
    else if (sec_wrap)
      alarm_next = ({hr1_next, hr0_next} == alarm_h_bcd) &&
                   ({min1_next, min0_next} == alarm_min_bcd);
  end
`endif

  always_ff @(posedge clk_in) begin
    if (rst) begin
      presc_reg        <= '0;
      sec_reg          <= '0;
      min0_reg         <= '0;
      min1_reg         <= '0;
      hr0_reg          <= '0;
      hr1_reg          <= '0;
      sec_tick_reg     <= 1'b0;
      colon_reg        <= 1'b0;
      inc_min_prev_reg <= 1'b0;
      inc_h_prev_reg   <= 1'b0;
`ifdef TIME_KEEPER_ALARM_EN
      alarm_reg        <= 1'b0;
`endif
    end else begin
      presc_reg        <= presc_next;
      sec_reg          <= sec_next;
      min0_reg         <= min0_next;
      min1_reg         <= min1_next;
      hr0_reg          <= hr0_next;
      hr1_reg          <= hr1_next;
      // Tick and colon are registered from the next prescaler value so they line up with it.
      sec_tick_reg     <= (presc_next == LAST);
      colon_reg        <= (presc_next < HALF);
      inc_min_prev_reg <= inc_min;
      inc_h_prev_reg   <= inc_h;
`ifdef TIME_KEEPER_ALARM_EN
      alarm_reg        <= alarm_next;
`endif
    end
  end

  assign d0_min_out = min0_reg;
  assign d1_min_out = min1_reg;
  assign d0_h_out   = hr0_reg;
  assign d1_h_out   = hr1_reg;
  assign sec_tick   = sec_tick_reg;
  assign colon_on   = colon_reg;
`ifdef TIME_KEEPER_ALARM_EN
  assign alarm_out  = alarm_reg;
`endif

endmodule

// File: tb/tb_time_keeper_bcd.sv
// Bench for time_keeper_bcd (TICKS_PER_SEC = 4): directed scenarios plus random stimulus,
// every cycle compared against a seconds-of-day reference model.
module tb_time_keeper_bcd;

  localparam int T  = 4;
  localparam int AH = 0;
  localparam int AM = 2;

  logic       clk_in = 1'b0;
  logic       rst = 1'b0, set_mode = 1'b0, inc_min = 1'b0, inc_h = 1'b0;
  logic       alarm_en_v = 1'b1;
  logic [3:0] d0_min_out, d1_min_out, d0_h_out, d1_h_out;
  logic       sec_tick, colon_on;
`ifdef TIME_KEEPER_ALARM_EN
  logic       alarm_out;
  logic [7:0] alarm_h_bcd   = {4'(AH / 10), 4'(AH % 10)};
  logic [7:0] alarm_min_bcd = {4'(AM / 10), 4'(AM % 10)};
`endif

  int vectors = 0;
  int errs    = 0;
  int cyc     = 0;
  int tick_cnt = 0;

  // Reference model state: time of day as integers, position within the second.
  int m_h = 0, m_m = 0, m_s = 0, m_ph = 0;
  bit m_tick = 0, m_colon = 0, m_pim = 0, m_pih = 0, m_alarm = 0;

  time_keeper_bcd #(.TICKS_PER_SEC(T)) dut (
    .clk_in(clk_in), .rst(rst), .set_mode(set_mode), .inc_min(inc_min), .inc_h(inc_h),
`ifdef TIME_KEEPER_ALARM_EN
    .alarm_en(alarm_en_v), .alarm_h_bcd(alarm_h_bcd), .alarm_min_bcd(alarm_min_bcd),
    .alarm_out(alarm_out),
`endif
    .d0_min_out(d0_min_out), .d1_min_out(d1_min_out), .d0_h_out(d0_h_out),
    .d1_h_out(d1_h_out), .sec_tick(sec_tick), .colon_on(colon_on)
  );

  always #5 clk_in = ~clk_in;

  task automatic model_edge(input bit r, input bit s, input bit im, input bit ih, input bit aen);
    bit rolled;
    int t;
    rolled = 1'b0;
    if (r) begin
      m_h = 0; m_m = 0; m_s = 0; m_ph = 0;
      m_tick = 0; m_colon = 0; m_pim = 0; m_pih = 0; m_alarm = 0;
    end else if (s) begin
      m_ph = 0; m_s = 0;
      if (im && !m_pim) m_m = (m_m + 1) % 60;
      if (ih && !m_pih) m_h = (m_h + 1) % 24;
      m_tick = 0; m_colon = 1; m_alarm = 0;
      m_pim = im; m_pih = ih;
    end else begin
      if (m_ph == T - 1) begin
        t = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
        m_h = t / 3600; m_m = (t / 60) % 60; m_s = t % 60;
        rolled = (m_s == 0);
      end
      m_ph = (m_ph + 1) % T;
      m_tick = (m_ph == T - 1);
      m_colon = (m_ph < T / 2);
      if (!aen) m_alarm = 0;
      else if (rolled) m_alarm = (m_h == AH) && (m_m == AM);
      m_pim = im; m_pih = ih;
    end
  endtask

  task automatic step(input bit r, input bit s, input bit im, input bit ih);
    logic [17:0] obs, exp;
    rst = r; set_mode = s; inc_min = im; inc_h = ih;
    @(posedge clk_in);
    model_edge(r, s, im, ih, alarm_en_v);
    #1;
    cyc++;
    if (sec_tick === 1'b1) tick_cnt++;
    obs = {d1_h_out, d0_h_out, d1_min_out, d0_min_out, sec_tick, colon_on};
    exp = {4'(m_h / 10), 4'(m_h % 10), 4'(m_m / 10), 4'(m_m % 10), m_tick, m_colon};
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL cycle%0d hh_mm_tick_colon observed=%h expected=%h", cyc, obs, exp);
    end
`ifdef TIME_KEEPER_ALARM_EN
    vectors++;
    assert (alarm_out === m_alarm) else begin
      errs++;
      $error("FAIL cycle%0d alarm_out observed=%b expected=%b", cyc, alarm_out, m_alarm);
    end
`endif
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  task automatic chk_time(input string tag, input int h, input int m);
    logic [15:0] obs, exp;
    obs = {d1_h_out, d0_h_out, d1_min_out, d0_min_out};
    exp = {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_val(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reset, then reach h:m by button pulses in set mode, then return to run mode.
  task automatic set_time(input int h, input int m);
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    for (int i = 0; i < h; i++) begin step(0, 1, 0, 1); step(0, 1, 0, 0); end
    for (int i = 0; i < m; i++) begin step(0, 1, 1, 0); step(0, 1, 0, 0); end
    step(0, 0, 0, 0);
  endtask

  initial begin
    // 1: reset for two cycles, then one minute of run time.
    step(1, 0, 1, 1);
    chk_time("reset_digits_1", 0, 0);
    step(1, 1, 0, 1);
    chk_time("reset_digits_2", 0, 0);
    chk_val("reset_tick", int'(sec_tick), 0);
    chk_val("reset_colon", int'(colon_on), 0);
    tick_cnt = 0;
    run(240);
    chk_time("one_minute", 0, 1);
    chk_val("ticks_one_minute", tick_cnt, 60);

    // 2: 09:59 -> 10:00 after one minute.
    set_time(9, 59);
    chk_time("set_0959", 9, 59);
    run(239);
    chk_time("run_to_1000", 10, 0);

    // 3: midnight rollover; 60 ticks in 240 cycles.
    set_time(23, 59);
    tick_cnt = 0;
    run(239);
    chk_time("midnight", 0, 0);
    chk_val("ticks_midnight", tick_cnt, 60);

    // 4: held button gives one increment; simultaneous edges both apply.
    set_time(10, 59);
    for (int i = 0; i < 20; i++) step(0, 1, 1, 0);
    chk_time("held_inc_min", 10, 0);
    step(0, 1, 0, 0);
    for (int i = 0; i < 13; i++) begin step(0, 1, 0, 1); step(0, 1, 0, 0); end
    chk_time("set_23", 23, 0);
    step(0, 1, 1, 1);
    chk_time("both_buttons", 0, 1);
    chk_val("set_colon", int'(colon_on), 1);

    // 5: reset mid-second at 12:34.
    set_time(12, 34);
    run(2);
    step(1, 0, 0, 0);
    chk_time("reset_mid_second", 0, 0);
    chk_val("reset_mid_tick", int'(sec_tick), 0);
    tick_cnt = 0;
    run(T);
    chk_val("resume_one_tick", tick_cnt, 1);

`ifdef TIME_KEEPER_ALARM_EN
    // 6: alarm at 00:02, high for one minute, cleared by alarm_en.
    step(1, 0, 0, 0);
    run(479);
    chk_val("alarm_before", int'(alarm_out), 0);
    run(1);
    chk_val("alarm_rise", int'(alarm_out), 1);
    run(239);
    chk_val("alarm_hold", int'(alarm_out), 1);
    run(1);
    chk_val("alarm_end", int'(alarm_out), 0);
    step(1, 0, 0, 0);
    run(500);
    alarm_en_v = 1'b0;
    run(1);
    chk_val("alarm_disable", int'(alarm_out), 0);
    alarm_en_v = 1'b1;
`endif

    // Random phase, starting just before midnight.
    set_time(23, 58);
    begin
      bit s, im, ih, r;
      s = 0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 59) == 0) s = ~s;
        im = ($urandom_range(0, 2) == 0);
        ih = ($urandom_range(0, 3) == 0);
        r  = ($urandom_range(0, 999) == 0);
        step(r, s, im, ih);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
